// File: rtl/systemverilog_bus_pkg.sv
// Shared types for the vld/adr/dat/rdy bus target: bus words, counters and FSM states.
package systemverilog_bus_pkg;

    typedef logic [31:0] adr_t;
    typedef logic [31:0] dat_t;
    typedef logic [15:0] cnt_t;

    localparam int WCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } tgt_state_t;

endpackage

// File: rtl/systemverilog_sat_cnt.sv
// Up-counter that sticks at all-ones instead of wrapping.
module systemverilog_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (inc && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + W'(1);
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/systemverilog_bus_target.sv
// Bus write target: wait-state FSM, word-addressed register bank with a registered side
// read port, and saturating counters for accepted and rejected writes.
module systemverilog_bus_target
    import systemverilog_bus_pkg::*;
#(
    parameter adr_t BASE = 32'h0000_0000,
    parameter int   AW   = 4,
    parameter int   WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_vld,
    input  adr_t          bus_adr,
    input  dat_t          bus_dat,
    output logic          bus_rdy,
    input  logic [AW-1:0] rd_adr,
    output dat_t          rd_dat,
    output cnt_t          wr_cnt,
    output cnt_t          err_cnt
);

    // The WAIT parameter hides the package literal, so the states get local aliases.
    localparam tgt_state_t S_IDLE = systemverilog_bus_pkg::IDLE;
    localparam tgt_state_t S_WAIT = systemverilog_bus_pkg::WAIT;
    localparam tgt_state_t S_ACK  = systemverilog_bus_pkg::ACK;

    localparam logic [WCNT_W-1:0] WAIT_M1 = (WAIT == 0) ? '0 : WCNT_W'(WAIT - 1);

    tgt_state_t        r_state, w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
    dat_t              r_bank [2**AW];
    dat_t              r_rd_dat;

    logic [29:0]       w_woff;
    logic              w_in_range;
    logic [AW-1:0]     w_idx;
    logic              w_wr_en;
    logic              w_err_en;
    logic              w_unused;

    // Work on word addresses; BASE is aligned so the byte offset bits drop out.
    assign w_woff     = bus_adr[31:2] - BASE[31:2];
    assign w_in_range = (w_woff[29:AW] == '0);
    assign w_idx      = w_woff[AW-1:0];
    assign w_unused   = &{1'b0, bus_adr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        unique case (r_state)
            S_IDLE: begin
                if (bus_vld) begin
                    if (WAIT == 0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = WAIT_M1;
                    end
                end
            end
            S_WAIT: begin
                // Initiator dropped vld before rdy: abandon without side effects.
                if (!bus_vld)
                    w_state_nxt = S_IDLE;
                else if (r_wcnt == '0)
                    w_state_nxt = S_ACK;
                else
                    w_wcnt_nxt = r_wcnt - 1'b1;
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus_rdy  = (r_state == S_ACK);
        w_wr_en  = bus_rdy && w_in_range;
        w_err_en = bus_rdy && !w_in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++)
                r_bank[i] <= '0;
        end else if (w_wr_en) begin
            r_bank[w_idx] <= bus_dat;
        end
    end

    // Registered read sees the pre-write value when it collides with a commit.
    always_ff @(posedge clk) begin
        if (rst)
            r_rd_dat <= '0;
        else
            r_rd_dat <= r_bank[rd_adr];
    end

    assign rd_dat = r_rd_dat;

    systemverilog_sat_cnt #(.W(16)) u_wr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_en),
        .cnt (wr_cnt)
    );

    systemverilog_sat_cnt #(.W(16)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err_en),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_systemverilog_bus_target.sv
// Directed bench: WAIT=2 and WAIT=0 targets plus a narrow counter for saturation.
module tb_systemverilog_bus_target;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld, vld0;
    logic [31:0] adr, adr0, dat, dat0;
    logic        rdy, rdy0;
    logic [3:0]  rd_adr, rd_adr0;
    logic [31:0] rd_dat, rd_dat0;
    logic [15:0] wr_cnt, err_cnt, wr_cnt0, err_cnt0;
    logic        sinc;
    logic [3:0]  scnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] obs_rd [16];
    logic [31:0] exp_bank [16];

    always #5 clk = ~clk;

    systemverilog_bus_target #(.BASE(BASE), .AW(4), .WAIT(2)) dut (
        .clk(clk), .rst(rst), .bus_vld(vld), .bus_adr(adr), .bus_dat(dat), .bus_rdy(rdy),
        .rd_adr(rd_adr), .rd_dat(rd_dat), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
    );

    systemverilog_bus_target #(.BASE(32'h0), .AW(4), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .bus_vld(vld0), .bus_adr(adr0), .bus_dat(dat0), .bus_rdy(rdy0),
        .rd_adr(rd_adr0), .rd_dat(rd_dat0), .wr_cnt(wr_cnt0), .err_cnt(err_cnt0)
    );

    systemverilog_sat_cnt #(.W(4)) u_sat (
        .clk(clk), .rst(rst), .inc(sinc), .cnt(scnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Entered #1 after a posedge (cycle 0); returns #1 after a posedge.
    task automatic bus_wr(input string tag, input bit sel, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        int first;
        int pulses;
        first  = -1;
        pulses = 0;
        if (sel) begin vld0 = 1'b1; adr0 = a; dat0 = d; end
        else     begin vld  = 1'b1; adr  = a; dat  = d; end
        for (int c = 0; c < lat + 4; c++) begin
            @(negedge clk);
            obs_rd[c] = rd_dat;
            if (sel ? rdy0 : rdy) begin
                pulses++;
                if (first < 0) first = c;
            end
            @(posedge clk); #1;
            if (first >= 0) begin
                if (sel) vld0 = 1'b0; else vld = 1'b0;
            end
        end
        if (sel) vld0 = 1'b0; else vld = 1'b0;
        chk({tag, " lat"}, first, lat);
        chk({tag, " pulses"}, pulses, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        rd_adr = idx;
        @(posedge clk);
        @(negedge clk);
        chk(tag, rd_dat, exp);
        @(posedge clk); #1;
    endtask

    task automatic bank_chk(input string tag);
        for (int i = 0; i < 16; i++) rd_chk(tag, 4'(i), exp_bank[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat;
        rst = 1'b1; vld = 1'b0; vld0 = 1'b0; adr = '0; adr0 = '0; dat = '0; dat0 = '0;
        rd_adr = '0; rd_adr0 = '0; sinc = 1'b0;
        for (int i = 0; i < 16; i++) exp_bank[i] = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle rdy", {31'b0, rdy}, 0);
            chk("idle rd_dat", rd_dat, 0);
            chk("idle wr_cnt", {16'b0, wr_cnt}, 0);
            chk("idle err_cnt", {16'b0, err_cnt}, 0);
            chk("idle rdy0", {31'b0, rdy0}, 0);
            @(posedge clk); #1;
        end

        // Basic write with two wait states
        bus_wr("basic", 1'b0, BASE + 32'h8, 32'hDEAD_BEEF, 3);
        exp_bank[2] = 32'hDEAD_BEEF;
        rd_chk("basic rd", 4'd2, 32'hDEAD_BEEF);
        chk("basic wr_cnt", {16'b0, wr_cnt}, 1);
        chk("basic err_cnt", {16'b0, err_cnt}, 0);

        // One word past the bank: acked, counted as error, bank untouched
        bus_wr("oor", 1'b0, BASE + 32'h40, 32'h1234_5678, 3);
        chk("oor err_cnt", {16'b0, err_cnt}, 1);
        chk("oor wr_cnt", {16'b0, wr_cnt}, 1);
        bank_chk("oor bank");

        // Last word in range, and an address just below BASE (wraps high)
        bus_wr("top", 1'b0, BASE + 32'h3C, 32'hF00D_F00D, 3);
        exp_bank[15] = 32'hF00D_F00D;
        bus_wr("below", 1'b0, BASE - 32'h4, 32'h0BAD_CAFE, 3);
        chk("edge wr_cnt", {16'b0, wr_cnt}, 2);
        chk("edge err_cnt", {16'b0, err_cnt}, 2);
        rd_chk("top rd", 4'd15, 32'hF00D_F00D);
        rd_chk("below rd0", 4'd0, 32'h0);

        // Abort: vld drops while in WAIT
        vld = 1'b1; adr = BASE + 32'hC; dat = 32'h0000_0BAD;
        @(posedge clk); #1;
        vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort rdy", {31'b0, rdy}, 0);
            @(posedge clk); #1;
        end
        chk("abort wr_cnt", {16'b0, wr_cnt}, 2);
        chk("abort err_cnt", {16'b0, err_cnt}, 2);
        rd_chk("abort rd", 4'd3, 32'h0);
        bus_wr("after abort", 1'b0, BASE + 32'hC, 32'h3333_3333, 3);
        exp_bank[3] = 32'h3333_3333;
        rd_chk("after abort rd", 4'd3, 32'h3333_3333);
        chk("after abort wr_cnt", {16'b0, wr_cnt}, 3);

        // Read-before-write on index 5; low address bits are ignored
        bus_wr("pre5", 1'b0, BASE + 32'h16, 32'h0000_0001, 3);
        rd_adr = 4'd5;
        bus_wr("rbw", 1'b0, BASE + 32'h14, 32'hA5A5_A5A5, 3);
        exp_bank[5] = 32'hA5A5_A5A5;
        chk("rbw during ack", obs_rd[3], 32'h1);
        chk("rbw old", obs_rd[4], 32'h1);
        chk("rbw new", obs_rd[5], 32'hA5A5_A5A5);
        chk("rbw wr_cnt", {16'b0, wr_cnt}, 5);
        bank_chk("final bank");

        // Zero wait states: single write, then vld held for back-to-back
        bus_wr("w0", 1'b1, 32'h0000_0004, 32'h0000_00AA, 1);
        vld0 = 1'b1; adr0 = 32'h8; dat0 = 32'h0000_00BB;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pat = 2'(c & 1);
            chk("b2b rdy", {31'b0, rdy0}, {31'b0, pat[0]});
            @(posedge clk); #1;
        end
        vld0 = 1'b0;
        chk("b2b wr_cnt", {16'b0, wr_cnt0}, 4);
        chk("b2b err_cnt", {16'b0, err_cnt0}, 0);

        // Saturation on a narrow counter instance
        sinc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            chk("sat cnt", {28'b0, scnt}, (i > 15) ? 32'd15 : 32'(i));
        end
        sinc = 1'b0;

        // Reset in the cycle before ACK clears everything
        vld = 1'b1; adr = BASE + 32'h20; dat = 32'h7777_7777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst pre rdy", {31'b0, rdy}, 0);
        @(posedge clk); #1;
        rst = 1'b0; vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst rdy", {31'b0, rdy}, 0);
            chk("rst wr_cnt", {16'b0, wr_cnt}, 0);
            chk("rst err_cnt", {16'b0, err_cnt}, 0);
            chk("rst rd_dat", rd_dat, 0);
            chk("rst sat", {28'b0, scnt}, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 16; i++) exp_bank[i] = '0;
        bank_chk("rst bank");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
